// File: rtl/led_pwm_driver_pkg.sv
// ---------------------------------------------------------------------------
// led_drv_pkg
//   Shared types and helpers for the N-channel LED PWM driver.
//   - led_mode_t : 2-bit runtime mode select (OFF / COUNT / PWM / BREATHE)
//   - ramp_dir_t : direction of the BREATHE brightness ramp
//   - addr_width : channel-index width, never narrower than one bit
// ---------------------------------------------------------------------------
package led_drv_pkg;

  typedef enum logic [1:0] {
    LED_MODE_OFF     = 2'd0,
    LED_MODE_COUNT   = 2'd1,
    LED_MODE_PWM     = 2'd2,
    LED_MODE_BREATHE = 2'd3
  } led_mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } ramp_dir_t;

  // A single-channel build still needs a 1-bit address port.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pwm_driver_prescaler.sv
// ---------------------------------------------------------------------------
// led_prescaler
//   Free-running power-of-two prescaler producing a registered one-cycle
//   strobe each time the W-bit counter wraps. Also usable for other slow
//   strobes in the fabric.
//   Ports:
//     clk    in  1  clock
//     reset  in  1  synchronous, active-high
//     tick   out 1  registered pulse, high for one cycle every 2**W cycles;
//                   first pulse 2**W cycles after reset is released
// ---------------------------------------------------------------------------
module led_prescaler #(
  parameter int unsigned W = 20
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt + W'(1);
      // Registered: tick is high in the cycle after the counter reads all-ones.
      tick <= (cnt == '1);
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// ---------------------------------------------------------------------------
// led_pwm_driver
//   Parametrised N-channel LED driver with per-channel PWM brightness, a
//   triangular "breathe" ramp, a decrementing COUNT pattern and a runtime
//   mode select. Ramp and count cadence come from an internal prescaler tick.
//   Ports:
//     clk      in  1       single clock
//     reset    in  1       synchronous, active-high; clears all state
//     mode     in  2       0 OFF, 1 COUNT, 2 PWM, 3 BREATHE (sampled each cycle)
//     wr_en    in  1       duty write strobe
//     wr_addr  in  ADDR_W  channel index; indices >= N_LEDS are ignored
//     wr_data  in  PWM_W   duty value
//     led      out N_LEDS  registered LED drive, 1 = on
//     tick     out 1       registered prescaler wrap pulse
// ---------------------------------------------------------------------------
module led_pwm_driver
  import led_drv_pkg::*;
#(
  parameter  int unsigned N_LEDS     = 4,
  parameter  int unsigned PRESCALE_W = 20,
  parameter  int unsigned PWM_W      = 8,
  localparam int unsigned ADDR_W     = addr_width(N_LEDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PWM_W-1:0]  wr_data,
  output logic [N_LEDS-1:0] led,
  output logic              tick
);

  led_mode_t          mode_in;
  led_mode_t          mode_q;
  logic               mode_chg;

  logic [PWM_W-1:0]   duty [N_LEDS];
  logic [PWM_W-1:0]   pwm_cnt;

  logic [N_LEDS-1:0]  pattern, pattern_nxt;
  logic [PWM_W-1:0]   bright, bright_nxt;
  ramp_dir_t          dir, dir_nxt;
  logic [N_LEDS-1:0]  led_nxt;

  led_prescaler #(
    .W(PRESCALE_W)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign mode_in  = led_mode_t'(mode);
  assign mode_chg = (mode_in != mode_q);

  // Next-state for the mode-dependent registers and the LED compare.
  // A mode change clears pattern/bright and suppresses any step that a
  // coincident tick would otherwise apply.
  always_comb begin
    pattern_nxt = pattern;
    bright_nxt  = bright;
    dir_nxt     = dir;
    led_nxt     = '0;

    if (mode_chg) begin
      pattern_nxt = '0;
      bright_nxt  = '0;
      dir_nxt     = DIR_UP;
    end else if (tick) begin
      unique case (mode_q)
        LED_MODE_COUNT: begin
          pattern_nxt = pattern - N_LEDS'(1);
        end
        LED_MODE_BREATHE: begin
          // Triangle ramp: the turnaround step already moves away from the
          // end value, so neither 0 nor max is held for two ticks.
          if (dir == DIR_UP) begin
            if (bright == '1) begin
              bright_nxt = bright - PWM_W'(1);
              dir_nxt    = DIR_DOWN;
            end else begin
              bright_nxt = bright + PWM_W'(1);
            end
          end else begin
            if (bright == '0) begin
              bright_nxt = bright + PWM_W'(1);
              dir_nxt    = DIR_UP;
            end else begin
              bright_nxt = bright - PWM_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end

    unique case (mode_q)
      LED_MODE_OFF: begin
        led_nxt = '0;
      end
      LED_MODE_COUNT: begin
        led_nxt = pattern;
      end
      LED_MODE_PWM: begin
        for (int unsigned i = 0; i < N_LEDS; i++) begin
          led_nxt[i] = (duty[i] > pwm_cnt);
        end
      end
      LED_MODE_BREATHE: begin
        for (int unsigned i = 0; i < N_LEDS; i++) begin
          led_nxt[i] = (bright > pwm_cnt);
        end
      end
      default: begin
        led_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= LED_MODE_OFF;
      pattern <= '0;
      bright  <= '0;
      dir     <= DIR_UP;
      pwm_cnt <= '0;
      led     <= '0;
      for (int unsigned i = 0; i < N_LEDS; i++) begin
        duty[i] <= '0;
      end
    end else begin
      mode_q  <= mode_in;
      pattern <= pattern_nxt;
      bright  <= bright_nxt;
      dir     <= dir_nxt;
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      led     <= led_nxt;
      // Decoding per channel drops out-of-range addresses without a
      // separate bounds compare.
      for (int unsigned i = 0; i < N_LEDS; i++) begin
        if (wr_en && (wr_addr == ADDR_W'(i))) begin
          duty[i] <= wr_data;
        end
      end
    end
  end

endmodule
